// File: rtl/uart_apb_tx.sv
// rtl/uart_apb_tx.sv - APB-slave UART transmitter with TX FIFO and frame formatting
//
// Ports:
//   clock, PRESET        single clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE  APB control; PADDR[4:2] selects THR/LCR/DIV/STATUS/IER
//   PWDATA/PRDATA        APB data; PRDATA is combinational in the access phase
//   PREADY/PSLVERR       zero-wait-state ready, access error
//   nCTS                 active-low clear-to-send, sampled only at frame start
//   TXD                  serial output, idle high
//   IRQ                  registered FIFO-empty-and-idle interrupt
//   tx_fifo_*            FIFO empty/full flags and occupancy
module uart_apb_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 16,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             PRESET,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic             nCTS,
    output logic             TXD,
    output logic             IRQ,
    output logic             tx_fifo_empty,
    output logic             tx_fifo_full,
    output logic [CNT_W-1:0] tx_fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [5:0]       r_lcr;
    logic [15:0]      r_div;
    logic             r_ier;
    logic             r_irq;

    state_t           r_state, w_next;
    logic [15:0]      r_baud, r_fdiv;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic             r_par, r_fstop2, r_fpar_en;
    logic [1:0]       r_fwl;

    logic [2:0]       w_idx;
    logic             w_access, w_full, w_empty, w_busy, w_err, w_wr;
    logic             w_push, w_pop, w_flush, w_can_start, w_bit_end, w_txd;
    logic [7:0]       w_fifo_data, w_mask;
    logic [15:0]      w_div_eff;
    logic [2:0]       w_last_bit;
    logic             w_par_new;
    logic [31:0]      w_rdata;
    logic             w_unused_bits;

    assign w_unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

    // APB decode
    assign w_access = PSEL & PENABLE;
    assign w_idx    = PADDR[4:2];
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_busy   = (r_state != S_IDLE);
    // Full is judged on the pre-edge count, so a simultaneous pop never rescues a push.
    assign w_err    = w_access & ((w_idx > 3'd4) |
                                  (PWRITE & (w_idx == 3'd3)) |
                                  (PWRITE & (w_idx == 3'd0) & w_full));
    assign w_wr     = w_access & PWRITE & ~w_err;
    assign w_push   = w_wr & (w_idx == 3'd0);
    assign w_flush  = w_wr & (w_idx == 3'd1) & PWDATA[6];

    always_comb begin
        w_rdata = '0;
        if (w_access && !PWRITE && !w_err) begin
            case (w_idx)
                3'd1: w_rdata[5:0]  = r_lcr;
                3'd2: w_rdata[15:0] = r_div;
                3'd3: begin
                    w_rdata[0]          = w_empty;
                    w_rdata[1]          = w_full;
                    w_rdata[2]          = w_busy;
                    w_rdata[8 +: CNT_W] = r_count;
                end
                3'd4: w_rdata[0] = r_ier;
                default: w_rdata = '0;
            endcase
        end
    end

    assign PRDATA  = w_rdata;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_err;

    // Control registers; the flush bit is an action, not stored state.
    always_ff @(posedge clock) begin
        if (PRESET) begin
            r_lcr <= 6'h03;
            r_div <= 16'(DEFAULT_DIV);
            r_ier <= 1'b0;
        end else if (w_wr) begin
            case (w_idx)
                3'd1: r_lcr <= PWDATA[5:0];
                3'd2: r_div <= PWDATA[15:0];
                3'd4: r_ier <= PWDATA[0];
                default: ;
            endcase
        end
    end

    // TX FIFO
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= PWDATA[7:0];
    end

    always_ff @(posedge clock) begin
        if (PRESET || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign tx_fifo_empty = w_empty;
    assign tx_fifo_full  = w_full;
    assign tx_fifo_count = r_count;
    assign w_fifo_data   = r_mem[r_rptr];

    // Frame setup values, taken from the live registers at the pop.
    assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
    always_comb begin
        case (r_lcr[1:0])
            2'd0:    w_mask = 8'h1F;
            2'd1:    w_mask = 8'h3F;
            2'd2:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end
    assign w_par_new   = (^(w_fifo_data & w_mask)) ^ ~r_lcr[4];
    assign w_can_start = !w_empty && (!r_lcr[5] || !nCTS);
    assign w_bit_end   = (r_baud == 16'd0);
    assign w_last_bit  = 3'd4 + {1'b0, r_fwl};

    always_ff @(posedge clock) begin
        if (PRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: if (w_can_start) begin
                w_pop  = 1'b1;
                w_next = S_START;
            end
            S_START: if (w_bit_end) w_next = S_DATA;
            S_DATA: if (w_bit_end && r_bitcnt == w_last_bit)
                w_next = r_fpar_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_next = S_STOP;
            S_STOP: if (w_bit_end && r_bitcnt == 3'd0) begin
                // Chain straight into the next start bit to avoid an idle gap.
                if (w_can_start) begin
                    w_pop  = 1'b1;
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bit timer and shifter; r_bitcnt counts data bits, then remaining extra stop bits.
    always_ff @(posedge clock) begin
        if (PRESET) begin
            r_baud    <= '0;
            r_fdiv    <= 16'd1;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_fwl     <= '0;
            r_fstop2  <= 1'b0;
            r_fpar_en <= 1'b0;
        end else if (w_pop) begin
            r_shift   <= w_fifo_data;
            r_fwl     <= r_lcr[1:0];
            r_fstop2  <= r_lcr[2];
            r_fpar_en <= r_lcr[3];
            r_par     <= w_par_new;
            r_fdiv    <= w_div_eff;
            r_baud    <= w_div_eff - 16'd1;
            r_bitcnt  <= '0;
        end else if (w_busy) begin
            if (w_bit_end) begin
                r_baud <= r_fdiv - 16'd1;
                case (r_state)
                    S_DATA: begin
                        r_shift <= r_shift >> 1;
                        if (r_bitcnt == w_last_bit) r_bitcnt <= {2'b00, r_fstop2};
                        else                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_bitcnt <= {2'b00, r_fstop2};
                    S_STOP:   r_bitcnt <= r_bitcnt - 3'd1;
                    default:  ;
                endcase
            end else begin
                r_baud <= r_baud - 16'd1;
            end
        end
    end

    always_comb begin
        case (r_state)
            S_START:  w_txd = 1'b0;
            S_DATA:   w_txd = r_shift[0];
            S_PARITY: w_txd = r_par;
            default:  w_txd = 1'b1;
        endcase
    end
    assign TXD = w_txd;

    always_ff @(posedge clock) begin
        if (PRESET) r_irq <= 1'b0;
        else        r_irq <= r_ier & w_empty & ~w_busy;
    end
    assign IRQ = r_irq;

endmodule

// File: tb/tb_uart_apb_tx.sv
// tb/tb_uart_apb_tx.sv - directed self-checking bench for uart_apb_tx
module tb_uart_apb_tx;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          PRESET = 1'b1;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0]   PADDR = '0, PWDATA = '0;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic          nCTS = 1'b1;
    logic          TXD, IRQ, tx_fifo_empty, tx_fifo_full;
    logic [CW-1:0] tx_fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_apb_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16)) dut (
        .clock(clock), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .nCTS(nCTS), .TXD(TXD), .IRQ(IRQ),
        .tx_fifo_empty(tx_fifo_empty), .tx_fifo_full(tx_fifo_full),
        .tx_fifo_count(tx_fifo_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(negedge clock);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge clock);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge clock);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(negedge clock);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge clock);
        PENABLE = 1'b1;
        #1 begin d = PRDATA; err = PSLVERR; end
        @(posedge clock);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Entered 1 time unit after the edge where the start bit begins.
    task automatic check_frame(input string name, input int div, input int nb, input logic [15:0] bits);
        logic ok, got;
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1; got = bits[b];
            for (int c = 0; c < div; c++) begin
                if (TXD !== bits[b]) begin ok = 1'b0; got = TXD; end
                @(posedge clock); #1;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s bit%0d: TXD=%b expected %b for %0d clocks", name, b, got, bits[b], div);
            end
        end
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 2000) begin
            @(posedge clock); #1; guard++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL wait_cyc: cyc=%0d expected %0d", cyc, target);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d; logic e;
        repeat (3) @(posedge clock);
        @(negedge clock); PRESET = 1'b0;
        #1;
        checks++;
        if ({PRDATA, PREADY, PSLVERR, TXD, IRQ, tx_fifo_empty, tx_fifo_full} !== {32'd0, 6'b101010}) begin
            errors++;
            $display("FAIL reset_outputs: got %h %b%b%b%b%b%b", PRDATA, PREADY, PSLVERR, TXD, IRQ, tx_fifo_empty, tx_fifo_full);
        end
        checks++;
        if (tx_fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", tx_fifo_count); end
        apb_read(32'h04, d, e);
        checks++; if (d !== 32'h03) begin errors++; $display("FAIL reset_lcr: got %h expected 03", d); end
        apb_read(32'h08, d, e);
        checks++; if (d !== 32'd16) begin errors++; $display("FAIL reset_div: got %0d expected 16", d); end
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ier: got %h expected 0", d); end
        apb_read(32'h0C, d, e);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %h expected 1", d); end
    endtask

    task automatic test_8n1;
        logic e;
        apb_write(32'h08, 32'd4, e);
        apb_write(32'h00, 32'hA5, e);
        checks++;
        if (e !== 1'b0 || tx_fifo_count !== 3'd1 || TXD !== 1'b1) begin
            errors++; $display("FAIL 8n1_push: err=%b count=%0d txd=%b expected 0 1 1", e, tx_fifo_count, TXD);
        end
        @(posedge clock); #1;
        checks++;
        if (tx_fifo_count !== 3'd0) begin errors++; $display("FAIL 8n1_pop: count=%0d expected 0", tx_fifo_count); end
        check_frame("8n1", 4, 10, {6'd0, 1'b1, 8'hA5, 1'b0});
    endtask

    task automatic test_parity;
        logic e;
        apb_write(32'h04, 32'h1C, e);
        apb_write(32'h08, 32'd2, e);
        apb_write(32'h00, 32'h13, e);
        @(posedge clock); #1;
        check_frame("5e2", 2, 9, {7'd0, 2'b11, 1'b1, 5'h13, 1'b0});
        checks++;
        if (TXD !== 1'b1 || tx_fifo_empty !== 1'b1) begin
            errors++; $display("FAIL 5e2_end: txd=%b empty=%b expected 1 1", TXD, tx_fifo_empty);
        end
    endtask

    task automatic test_back_to_back;
        logic e;
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h3C, 8'hF0, 8'h99};
        nCTS = 1'b1;
        apb_write(32'h04, 32'h23, e);
        apb_write(32'h08, 32'd1, e);
        for (int i = 0; i < 5; i++) begin
            apb_write(32'h00, {24'd0, bytes[i]}, e);
            checks++;
            if (e !== (i == 4)) begin errors++; $display("FAIL b2b_pslverr%0d: got %b expected %b", i, e, (i == 4)); end
        end
        repeat (3) @(posedge clock); #1;
        checks++;
        if (tx_fifo_full !== 1'b1 || tx_fifo_count !== 3'd4 || TXD !== 1'b1) begin
            errors++; $display("FAIL b2b_full: full=%b count=%0d txd=%b expected 1 4 1", tx_fifo_full, tx_fifo_count, TXD);
        end
        @(negedge clock); nCTS = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (tx_fifo_count !== 3'd3) begin errors++; $display("FAIL b2b_pop: count=%0d expected 3", tx_fifo_count); end
        for (int i = 0; i < 4; i++) check_frame("b2b", 1, 10, {6'd0, 1'b1, bytes[i], 1'b0});
        check_frame("b2b_idle", 1, 5, 16'h001F);
        checks++;
        if (tx_fifo_count !== 3'd0 || tx_fifo_empty !== 1'b1) begin
            errors++; $display("FAIL b2b_drain: count=%0d empty=%b expected 0 1", tx_fifo_count, tx_fifo_empty);
        end
    endtask

    task automatic test_irq_err;
        logic e; logic [31:0] d;
        nCTS = 1'b1;
        apb_write(32'h04, 32'h03, e);
        apb_write(32'h10, 32'h01, e);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", IRQ); end
        @(posedge clock); #1;
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", IRQ); end
        apb_write(32'h00, 32'h5A, e);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_push: got %b expected 1", IRQ); end
        @(posedge clock); #1;
        checks++;
        if (IRQ !== 1'b0 || TXD !== 1'b0) begin errors++; $display("FAIL irq_start: irq=%b txd=%b expected 0 0", IRQ, TXD); end
        repeat (9) @(posedge clock); #1;
        checks++;
        if (IRQ !== 1'b0 || TXD !== 1'b1) begin errors++; $display("FAIL irq_stop: irq=%b txd=%b expected 0 1", IRQ, TXD); end
        @(posedge clock); #1;
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_idle_edge: got %b expected 0", IRQ); end
        @(posedge clock); #1;
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", IRQ); end
        apb_read(32'h14, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL err_rd14: err=%b data=%h expected 1 0", e, d); end
        apb_write(32'h0C, 32'hFFFF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr0c: got %b expected 1", e); end
        apb_read(32'h10, d, e);
        checks++;
        if (e !== 1'b0 || d !== 32'h1) begin errors++; $display("FAIL ier_read: err=%b data=%h expected 0 1", e, d); end
    endtask

    task automatic test_flush;
        logic e; int t1; logic [9:0] fb;
        fb = {1'b1, 8'hC3, 1'b0};
        nCTS = 1'b1;
        apb_write(32'h04, 32'h23, e);
        apb_write(32'h08, 32'd8, e);
        apb_write(32'h00, 32'hC3, e);
        apb_write(32'h00, 32'h11, e);
        apb_write(32'h00, 32'h22, e);
        @(negedge clock); nCTS = 1'b0;
        @(posedge clock); #1;
        t1 = cyc;
        checks++;
        if (TXD !== 1'b0 || tx_fifo_count !== 3'd2) begin
            errors++; $display("FAIL flush_start: txd=%b count=%0d expected 0 2", TXD, tx_fifo_count);
        end
        nCTS = 1'b1;
        apb_write(32'h04, 32'h43, e);
        checks++;
        if (e !== 1'b0 || tx_fifo_count !== 3'd0) begin
            errors++; $display("FAIL flush_count: err=%b count=%0d expected 0 0", e, tx_fifo_count);
        end
        nCTS = 1'b0;
        for (int b = 1; b < 10; b++) begin
            wait_cyc(t1 + 8 * b + 4);
            checks++;
            if (TXD !== fb[b]) begin errors++; $display("FAIL flush_frame bit%0d: got %b expected %b", b, TXD, fb[b]); end
        end
        wait_cyc(t1 + 80);
        check_frame("flush_idle", 1, 16, 16'hFFFF);
    endtask

    task automatic test_reset_mid;
        logic e; logic [31:0] d;
        for (int i = 1; i <= 4; i++) apb_write(32'h00, i, e);
        checks++;
        if (tx_fifo_count !== 3'd3) begin errors++; $display("FAIL rst_queued: count=%0d expected 3", tx_fifo_count); end
        repeat (8) @(posedge clock);
        @(negedge clock); PRESET = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (TXD !== 1'b1 || tx_fifo_count !== 3'd0 || tx_fifo_empty !== 1'b1 || IRQ !== 1'b0) begin
            errors++; $display("FAIL rst_mid: txd=%b count=%0d empty=%b irq=%b expected 1 0 1 0", TXD, tx_fifo_count, tx_fifo_empty, IRQ);
        end
        @(negedge clock); PRESET = 1'b0;
        #1;
        check_frame("rst_quiet", 10, 12, 16'hFFFF);
        apb_read(32'h08, d, e);
        checks++; if (d !== 32'd16) begin errors++; $display("FAIL rst_div: got %0d expected 16", d); end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_back_to_back;
        test_irq_err;
        test_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_apb_tx.md
# uart_apb_tx

APB-slave UART transmitter with a parametrised transmit FIFO, programmable frame format, a 16-bit baud divisor, optional nCTS flow control and an empty interrupt. It sits between the APB bus and the TXD pin. It generalises the transmit path of the existing UART interface in three ways: FIFO depth is a parameter, frames are 5–8 data bits with optional parity and 1/2 stop bits, and back-to-back frames are sent without idle gaps.

## Interface
- FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2
- DEFAULT_DIV, 16, reset value of DIV (clocks per bit)
- CNT_W, $clog2(FIFO_DEPTH+1), width of tx_fifo_count
- clock  in  1  single clock for all logic
- PRESET  in  1  reset; synchronous, active-high
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  32  APB address; bits [4:2] decoded, others ignored
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  always 1 (zero wait states)
- PSLVERR  out  1  access error
- nCTS  in  1  clear-to-send, active-low
- TXD  out  1  serial output, idle high
- IRQ  out  1  interrupt
- tx_fifo_empty, tx_fifo_full  out  1  FIFO flags
- tx_fifo_count  out  CNT_W  FIFO occupancy

## Operation
- Access phase: PSEL & PENABLE. Writes take effect at that clock edge. PRDATA and PSLVERR are combinational in the access phase and 0 otherwise.
- Register map:
  - 0x00 THR (W): push PWDATA[7:0] into the FIFO. Reads return 0.
  - 0x04 LCR (R/W, reset 0x03):
    - [1:0] word length = 5 + value
    - [2] 2 stop bits
    - [3] parity enable
    - [4] even parity (0 = odd)
    - [5] CTS enable
    - [6] FIFO flush: write-1, self-clearing, reads 0
  - 0x08 DIV (R/W, reset DEFAULT_DIV): [15:0] clocks per bit. Value 0 behaves as 1.
  - 0x0C STATUS (RO): [0] empty, [1] full, [2] busy, [8+:CNT_W] count.
  - 0x10 IER (R/W, reset 0): [0] empty-interrupt enable.
- PSLVERR = 1 in these cases, with no state change:
  - address ≥ 0x14
  - write to STATUS
  - THR write while full (data dropped)
- Full is judged on the pre-edge count. A push on a full FIFO is rejected even if a pop happens on the same edge.
- A push and pop on the same edge when not full and not empty leave the count unchanged.
- Flush empties the FIFO. A frame already in progress completes. A THR write cannot coincide with a flush (single APB access).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty and (!LCR[5] or nCTS == 0), pop, latch the data byte plus LCR/DIV for the frame, and go to START.
  - START: TXD = 0. Then DATA.
  - DATA: data bits LSB first, count = word length. Then PARITY if enabled, else STOP.
  - PARITY: even parity bit = XOR of the data bits; odd parity = its inverse.
  - STOP: TXD = 1 for 1 or 2 bit periods. At the end, if the IDLE pop condition holds, pop and go directly to START. Otherwise go to IDLE.
- Each bit lasts exactly DIV clocks, counted by a 16-bit down-counter reloaded at each bit boundary.
- LCR/DIV writes made mid-frame apply from the next frame.
- nCTS is only checked at frame start. Deasserting it mid-frame does not abort the frame.
- busy = state != IDLE.
- IRQ (registered) = IER[0] & empty & !busy.

## Timing
- Reset values:
  - PRDATA 0, PREADY 1, PSLVERR 0
  - TXD 1, IRQ 0
  - tx_fifo_empty 1, tx_fifo_full 0, tx_fifo_count 0
  - FSM IDLE, LCR 0x03, DIV DEFAULT_DIV, IER 0
- THR write at edge E0 sets count = 1 after E0. If idle, the pop happens at E1, TXD falls after E1, and count returns to 0 after E1.
- Frame length = DIV × (1 + WL + P + S) clocks.
- Back-to-back frames: the next start bit immediately follows the last stop-bit clock, with zero idle cycles.
- FIFO flags and count are registered and update on the same edge as the push/pop.
- IRQ changes one clock after its inputs change.
- PRESET asserted mid-frame: at the next edge TXD = 1, the FIFO is cleared, the FSM is in IDLE and all registers take their reset values.

## Test plan
- Reset, DIV = 4, 8N1, write THR 0xA5 → TXD low 1 cycle after the FIFO count becomes 1. Bits on TXD: 0, 1,0,1,0,0,1,0,1, 1, each 4 clocks, 40 clocks total.
- LCR = 0x1C (5 bits, 2 stop, even parity), DIV = 2, write 0x13 → TXD: 0, 1,1,0,0,1, parity 1, 1,1; 18 clocks total.
- Write FIFO_DEPTH+1 bytes while nCTS = 1 and LCR[5] = 1 → full = 1 and count = FIFO_DEPTH. The extra write gets PSLVERR = 1. Then nCTS = 0 → FIFO_DEPTH back-to-back frames with no idle gap.
- IER = 1, send one byte with DIV = 1 → IRQ = 0 during the frame and rises 1 clock after busy falls. Reads of 0x14 and writes of 0x0C → PSLVERR = 1.
- Assert PRESET mid-data-bit with 3 bytes queued → TXD = 1 and count = 0 after the next edge, and no further frame is sent. An LCR flush with bytes queued → count = 0 and the current frame completes.
